// File: rtl/bfp_exp_detect_if.sv
// Bus bundle for the BFP exponent detector: per-beat complex lanes in, delayed lanes,
// per-beat minimum redundant-sign count and frame statistics out.
interface bfp_exp_detect_if #(
  parameter int I_WIDTH    = 23,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 5
);

  // A beat transfers on every cycle its valid is 1; there is no ready, so the
  // consumer must accept every beat it is offered (no backpressure).
  logic signed [I_WIDTH-1:0] din_re  [DATA_WIDTH];
  logic signed [I_WIDTH-1:0] din_im  [DATA_WIDTH];
  logic                      din_valid;

  logic signed [I_WIDTH-1:0] dout_re [DATA_WIDTH];
  logic signed [I_WIDTH-1:0] dout_im [DATA_WIDTH];
  logic                      dout_valid;
  logic [CNT_WIDTH-1:0]      min_cnt;
  logic [CNT_WIDTH-1:0]      frame_min;
  logic                      frame_done;

  modport master (
    output din_re, din_im, din_valid,
    input  dout_re, dout_im, dout_valid, min_cnt, frame_min, frame_done
  );

  modport slave (
    input  din_re, din_im, din_valid,
    output dout_re, dout_im, dout_valid, min_cnt, frame_min, frame_done
  );

endinterface

// File: rtl/bfp_exp_detect.sv
// Block-floating-point exponent detector: per-beat minimum redundant-sign count over all
// lanes, data delayed to stay aligned with it, plus a running per-frame minimum.
module bfp_exp_detect #(
  parameter int I_WIDTH     = 23,
  parameter int DATA_WIDTH  = 16,
  parameter int CNT_WIDTH   = 5,
  parameter int FRAME_BEATS = 32
) (
  input  logic            clk,
  input  logic            rstn,
  bfp_exp_detect_if.slave bus
);

  localparam int GROUPS = (DATA_WIDTH + 3) / 4;
  localparam int BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

  typedef logic signed [I_WIDTH-1:0] sample_t;
  typedef logic [CNT_WIDTH-1:0]      cnt_t;
  typedef logic [BEAT_W-1:0]         beat_t;

  localparam cnt_t  CNT_MAX   = cnt_t'(I_WIDTH - 1);
  localparam beat_t LAST_BEAT = beat_t'(FRAME_BEATS - 1);

  // Counts bits below the sign that still equal the sign, stopping at the first change.
  function automatic cnt_t rsc(input sample_t x);
    cnt_t c;
    logic run;
    c   = '0;
    run = 1'b1;
    for (int b = I_WIDTH - 2; b >= 0; b--) begin
      if (run && (x[b] == x[I_WIDTH-1])) c = c + cnt_t'(1);
      else                               run = 1'b0;
    end
    return c;
  endfunction

  function automatic cnt_t cmin(input cnt_t a, input cnt_t b);
    return (a < b) ? a : b;
  endfunction

  // ---------------- stage 1: per-lane counts ----------------
  sample_t s1_re_q   [DATA_WIDTH];
  sample_t s1_im_q   [DATA_WIDTH];
  cnt_t    lane_cnt_d[DATA_WIDTH];
  cnt_t    lane_cnt_q[DATA_WIDTH];
  logic    s1_valid_q;

  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) begin
      lane_cnt_d[i] = cmin(rsc(bus.din_re[i]), rsc(bus.din_im[i]));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        s1_re_q[i]    <= '0;
        s1_im_q[i]    <= '0;
        lane_cnt_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= bus.din_valid;
      if (bus.din_valid) begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
          s1_re_q[i]    <= bus.din_re[i];
          s1_im_q[i]    <= bus.din_im[i];
          lane_cnt_q[i] <= lane_cnt_d[i];
        end
      end
    end
  end

  // ---------------- stage 2: groups of four lanes ----------------
  sample_t s2_re_q  [DATA_WIDTH];
  sample_t s2_im_q  [DATA_WIDTH];
  cnt_t    group_d  [GROUPS];
  cnt_t    group_q  [GROUPS];
  logic    s2_valid_q;

  // A partial last group is padded with the largest count so it never wins the min.
  always_comb begin
    for (int g = 0; g < GROUPS; g++) begin
      group_d[g] = CNT_MAX;
      for (int j = 0; j < 4; j++) begin
        if (g * 4 + j < DATA_WIDTH) group_d[g] = cmin(group_d[g], lane_cnt_q[g * 4 + j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid_q <= 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        s2_re_q[i] <= '0;
        s2_im_q[i] <= '0;
      end
      for (int g = 0; g < GROUPS; g++) group_q[g] <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
          s2_re_q[i] <= s1_re_q[i];
          s2_im_q[i] <= s1_im_q[i];
        end
        for (int g = 0; g < GROUPS; g++) group_q[g] <= group_d[g];
      end
    end
  end

  // ---------------- stage 3: beat minimum and outputs ----------------
  sample_t dout_re_q [DATA_WIDTH];
  sample_t dout_im_q [DATA_WIDTH];
  cnt_t    beat_min_d;
  cnt_t    min_cnt_q;
  logic    dout_valid_q;

  always_comb begin
    beat_min_d = CNT_MAX;
    for (int g = 0; g < GROUPS; g++) beat_min_d = cmin(beat_min_d, group_q[g]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_valid_q <= 1'b0;
      min_cnt_q    <= '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        dout_re_q[i] <= '0;
        dout_im_q[i] <= '0;
      end
    end else begin
      dout_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        min_cnt_q <= beat_min_d;
        for (int i = 0; i < DATA_WIDTH; i++) begin
          dout_re_q[i] <= s2_re_q[i];
          dout_im_q[i] <= s2_im_q[i];
        end
      end
    end
  end

  // ---------------- frame accumulator ----------------
  // Driven by the beat entering the output register so frame_done lines up with
  // the dout_valid of the frame's last beat.
  beat_t beat_cnt_q,   beat_cnt_d;
  cnt_t  run_min_q,    run_min_d;
  cnt_t  frame_min_q,  frame_min_d;
  logic  frame_done_q, frame_done_d;

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    run_min_d    = run_min_q;
    frame_min_d  = frame_min_q;
    frame_done_d = 1'b0;
    if (s2_valid_q) begin
      if (beat_cnt_q == LAST_BEAT) begin
        frame_min_d  = cmin(run_min_q, beat_min_d);
        frame_done_d = 1'b1;
        run_min_d    = CNT_MAX;
        beat_cnt_d   = '0;
      end else begin
        run_min_d  = cmin(run_min_q, beat_min_d);
        beat_cnt_d = beat_cnt_q + beat_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_q   <= '0;
      run_min_q    <= CNT_MAX;
      frame_min_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      run_min_q    <= run_min_d;
      frame_min_q  <= frame_min_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.dout_re    = dout_re_q;
  assign bus.dout_im    = dout_im_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.min_cnt    = min_cnt_q;
  assign bus.frame_min  = frame_min_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bfp_exp_detect.sv
// Bench for bfp_exp_detect: directed and random beats checked every cycle against a
// behavioural model, plus literal expectations for reset, latency and frame statistics.
module tb_bfp_exp_detect;

  localparam int I_W = 23;
  localparam int DW  = 16;
  localparam int CW  = 5;
  localparam int FB  = 32;
  localparam int PW  = 2 * DW * I_W;

  typedef logic signed [I_W-1:0] sample_t;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bfp_exp_detect_if #(.I_WIDTH(I_W), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  bfp_exp_detect #(.I_WIDTH(I_W), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .FRAME_BEATS(FB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // Largest k such that x fits in I_W-k bits signed, i.e. -2^(I_W-1-k) <= x < 2^(I_W-1-k).
  function automatic int rsc_ref(input sample_t x);
    longint v;
    longint lim;
    v = longint'(x);
    for (int k = I_W - 1; k >= 0; k--) begin
      lim = longint'(1) << (I_W - 1 - k);
      if (v >= -lim && v < lim) return k;
    end
    return 0;
  endfunction

  logic [PW-1:0] beat_q[$];
  int            cnt_q[$];
  int            frame_cnts[$];
  logic          v1, v2;
  logic          e_valid, e_done;
  logic [PW-1:0] e_data;
  int            e_cnt, e_fmin;
  logic [PW-1:0] m_pack;
  int            m_min;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_q.delete();
      cnt_q.delete();
      frame_cnts.delete();
      v1 = 1'b0; v2 = 1'b0;
      e_valid = 1'b0; e_done = 1'b0;
      e_data = '0; e_cnt = 0; e_fmin = 0;
    end else begin
      if (bus.din_valid) begin
        m_min = I_W - 1;
        for (int i = 0; i < DW; i++) begin
          m_pack[2*i*I_W +: I_W]     = bus.din_re[i];
          m_pack[(2*i+1)*I_W +: I_W] = bus.din_im[i];
          if (rsc_ref(bus.din_re[i]) < m_min) m_min = rsc_ref(bus.din_re[i]);
          if (rsc_ref(bus.din_im[i]) < m_min) m_min = rsc_ref(bus.din_im[i]);
        end
        beat_q.push_back(m_pack);
        cnt_q.push_back(m_min);
      end
      e_valid = v2;
      v2      = v1;
      v1      = bus.din_valid;
      e_done  = 1'b0;
      if (e_valid && beat_q.size() > 0) begin
        e_data = beat_q.pop_front();
        e_cnt  = cnt_q.pop_front();
        frame_cnts.push_back(e_cnt);
        if (frame_cnts.size() == FB) begin
          e_fmin = I_W - 1;
          foreach (frame_cnts[k]) if (frame_cnts[k] < e_fmin) e_fmin = frame_cnts[k];
          e_done = 1'b1;
          frame_cnts.delete();
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [PW-1:0] c_pack;

  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < DW; i++) begin
        c_pack[2*i*I_W +: I_W]     = bus.dout_re[i];
        c_pack[(2*i+1)*I_W +: I_W] = bus.dout_im[i];
      end
      check("dout_valid", 64'(bus.dout_valid), 64'(e_valid));
      check("min_cnt",    64'(bus.min_cnt),    64'(e_cnt));
      check("frame_done", 64'(bus.frame_done), 64'(e_done));
      check("frame_min",  64'(bus.frame_min),  64'(e_fmin));
      check_vec("dout_data", c_pack, e_data);
    end
  end

  // Output-beat bookkeeping used by the literal frame checks.
  int out_beats, done_cnt, done_at;

  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      out_beats = 0; done_cnt = 0; done_at = -1;
    end else if (bus.dout_valid) begin
      if (bus.frame_done) begin
        done_cnt++;
        done_at = out_beats;
      end
      out_beats++;
    end
  end

  // ---------------- driver tasks ----------------
  sample_t tre [DW];
  sample_t tim [DW];

  function automatic sample_t rand_sample();
    logic [31:0] r;
    int sh;
    r  = $urandom;
    sh = $urandom_range(0, I_W);
    return $signed(r[I_W-1:0]) >>> sh;
  endfunction

  task automatic set_zero();
    for (int i = 0; i < DW; i++) begin tre[i] = '0; tim[i] = '0; end
  endtask

  task automatic set_rand();
    for (int i = 0; i < DW; i++) begin tre[i] = rand_sample(); tim[i] = rand_sample(); end
  endtask

  task automatic put(input logic v);
    for (int i = 0; i < DW; i++) begin
      bus.din_re[i] = tre[i];
      bus.din_im[i] = tim[i];
    end
    bus.din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin set_rand(); put(1'b0); end
  endtask

  task automatic directed(input string name, input int want);
    put(1'b1);
    idle(3);
    check(name, 64'(bus.min_cnt), 64'(want));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rstn = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    for (int i = 0; i < DW; i++) begin
      c_pack[2*i*I_W +: I_W]     = bus.dout_re[i];
      c_pack[(2*i+1)*I_W +: I_W] = bus.dout_im[i];
    end
    check("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
    check("rst_min_cnt",    64'(bus.min_cnt),    64'd0);
    check("rst_frame_min",  64'(bus.frame_min),  64'd0);
    check("rst_frame_done", 64'(bus.frame_done), 64'd0);
    check_vec("rst_dout_data", c_pack, '0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    set_zero();
    for (int i = 0; i < DW; i++) begin bus.din_re[i] = '0; bus.din_im[i] = '0; end
    bus.din_valid = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // literal pins on the reference count
    check("ref_rsc_0",      64'(rsc_ref(sample_t'(0))),           64'd22);
    check("ref_rsc_m1",     64'(rsc_ref(sample_t'(-1))),          64'd22);
    check("ref_rsc_1",      64'(rsc_ref(sample_t'(1))),           64'd21);
    check("ref_rsc_4096",   64'(rsc_ref(sample_t'(4096))),        64'd9);
    check("ref_rsc_maxpos", 64'(rsc_ref(sample_t'(4194303))),     64'd0);
    check("ref_rsc_minneg", 64'(rsc_ref(sample_t'(-32'sd4194304))), 64'd0);

    // latency: first dout_valid exactly 3 cycles after the first din_valid
    set_zero(); tre[5] = sample_t'(1);
    put(1'b1);
    check("lat_c1", 64'(bus.dout_valid), 64'd0);
    idle(1);
    check("lat_c2", 64'(bus.dout_valid), 64'd0);
    idle(1);
    check("lat_c3", 64'(bus.dout_valid), 64'd1);
    idle(1);
    check("lat_hold_valid", 64'(bus.dout_valid), 64'd0);
    check("lat_min_21",     64'(bus.min_cnt),    64'd21);

    set_zero(); tre[5] = sample_t'(4096);
    directed("rsc_4096", 9);
    set_zero(); tim[5] = sample_t'(-32'sd4194304);
    directed("rsc_minneg", 0);
    for (int i = 0; i < DW; i++) begin
      tre[i] = ($urandom_range(0, 1) != 0) ? sample_t'(-1) : sample_t'(0);
      tim[i] = ($urandom_range(0, 1) != 0) ? sample_t'(-1) : sample_t'(0);
    end
    directed("rsc_zero_m1", 22);

    // one value walked through every lane's re and im
    for (int k = 0; k < 2 * DW; k++) begin
      set_zero();
      if (k < DW) tre[k] = sample_t'(1);
      else        tim[k - DW] = sample_t'(1);
      directed("lane_walk", 21);
    end

    // random burst with a 2-cycle bubble after beat 7
    for (int b = 0; b < 20; b++) begin
      set_rand();
      put(1'b1);
      if (b == 7) idle(2);
    end
    idle(4);

    // mid-stream asynchronous reset, then frame statistics
    do_reset();
    for (int b = 0; b < FB; b++) begin
      set_zero();
      if (b == 17) tre[3] = sample_t'(131072);
      put(1'b1);
    end
    idle(5);
    check("frame1_min",     64'(bus.frame_min), 64'd4);
    check("frame1_dones",   64'(done_cnt),      64'd1);
    check("frame1_done_at", 64'(done_at),       64'd31);
    for (int b = 0; b < FB; b++) begin set_zero(); put(1'b1); end
    idle(5);
    check("frame2_min",     64'(bus.frame_min), 64'd22);
    check("frame2_dones",   64'(done_cnt),      64'd2);
    check("frame2_done_at", 64'(done_at),       64'd63);

    // reset mid-frame: pre-reset beats must not leak into the next frame
    do_reset();
    for (int b = 0; b < 10; b++) begin
      set_zero();
      if (b == 2) tre[0] = sample_t'(-32'sd4194304);
      put(1'b1);
    end
    idle(4);
    check("pre_rst_beats", 64'(out_beats), 64'd10);
    check("pre_rst_dones", 64'(done_cnt),  64'd0);
    do_reset();
    for (int b = 0; b < FB; b++) begin
      set_zero();
      if (b == 20) tim[7] = sample_t'(16384);
      put(1'b1);
    end
    idle(5);
    check("post_rst_min",     64'(bus.frame_min), 64'd7);
    check("post_rst_dones",   64'(done_cnt),      64'd1);
    check("post_rst_done_at", 64'(done_at),       64'd31);

    // long random stream with random bubbles
    for (int c = 0; c < 400; c++) begin
      set_rand();
      put($urandom_range(0, 3) != 0);
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
